input_pre_sram_ctrl: RTL and testbench

INPUT_PRE_SRAM_CTRL -- requirements
Module: input_pre_sram_ctrl

---
 rtl/input_pre_sram_ctrl_if.sv | 33 +++
 rtl/input_pre_sram_ctrl.sv | 149 ++++++++++++++
 tb/tb_input_pre_sram_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/input_pre_sram_ctrl_if.sv
// Stream and SRAM bus bundle for the input pre-SRAM controller.
// master = controller side, slave = environment (producer, PE array, SRAM macro).
interface input_pre_sram_ctrl_if #(
  parameter int DW = 8,
  parameter int AW = 10,
  parameter int MW = 1
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          sram_cs;
  logic          sram_we;
  logic [MW-1:0] sram_wem;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic [DW-1:0] sram_dout;

  modport master (
    input  in_valid, in_data, out_ready, sram_dout,
    output in_ready, out_valid, out_data, out_last,
    output sram_cs, sram_we, sram_wem, sram_addr, sram_din
  );

  modport slave (
    output in_valid, in_data, out_ready, sram_dout,
    input  in_ready, out_valid, out_data, out_last,
    input  sram_cs, sram_we, sram_wem, sram_addr, sram_din
  );
endinterface

// File: rtl/input_pre_sram_ctrl.sv
// Loads one frame into SRAM from a stream, then replays it (cfg_rpt+1) times
// to the PE array with a valid/ready stream and a one-cycle done pulse.
module input_pre_sram_ctrl #(
  parameter int DP = 768,
  parameter int DW = 8,
  parameter int AW = 10,
  parameter int MW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [AW-1:0]         cfg_len,
  input  logic [3:0]            cfg_rpt,
  output logic                  busy,
  output logic                  done,
  input_pre_sram_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, LOAD, READ, DONE} state_e;

  localparam logic [AW-1:0] DP_L = AW'(DP);

  state_e        state_q, state_d;
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic [AW-1:0] rd_cnt_q, rd_cnt_d;
  logic [AW-1:0] len_q, len_d;
  logic [3:0]    pass_cnt_q, pass_cnt_d;
  logic [3:0]    rpt_q, rpt_d;
  logic          out_valid_q, out_valid_d;
  logic          last_q, last_d;

  logic          rd_issue;
  logic          out_xfer;
  logic          in_ready;
  logic          sram_cs;
  logic          sram_we;
  logic [MW-1:0] sram_wem;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      len_q       <= '0;
      pass_cnt_q  <= '0;
      rpt_q       <= '0;
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      len_q       <= len_d;
      pass_cnt_q  <= pass_cnt_d;
      rpt_q       <= rpt_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    len_d       = len_q;
    pass_cnt_d  = pass_cnt_q;
    rpt_d       = rpt_q;
    out_valid_d = 1'b0;
    last_d      = last_q;
    rd_issue    = 1'b0;
    out_xfer    = 1'b0;
    in_ready    = 1'b0;
    done        = 1'b0;
    sram_cs     = 1'b0;
    sram_we     = 1'b0;
    sram_wem    = '0;
    sram_addr   = '0;
    sram_din    = '0;

    case (state_q)
      IDLE: begin
        if (start && (cfg_len != '0)) begin
          state_d    = LOAD;
          len_d      = (cfg_len > DP_L) ? DP_L : cfg_len;
          rpt_d      = cfg_rpt;
          wr_cnt_d   = '0;
          rd_cnt_d   = '0;
          pass_cnt_d = '0;
        end
      end

      LOAD: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          sram_cs   = 1'b1;
          sram_we   = 1'b1;
          sram_wem  = '1;
          sram_addr = wr_cnt_q;
          sram_din  = bus.in_data;
          wr_cnt_d  = wr_cnt_q + AW'(1);
          if (wr_cnt_q == len_q - AW'(1)) state_d = READ;
        end
      end

      READ: begin
        // A read is only issued when the word it replaces is leaving, so
        // sram_dout (and out_data) holds steady through a stall.
        out_xfer = out_valid_q & bus.out_ready;
        rd_issue = (rd_cnt_q < len_q) && (!out_valid_q || bus.out_ready);
        if (rd_issue) begin
          sram_cs   = 1'b1;
          sram_addr = rd_cnt_q;
          rd_cnt_d  = rd_cnt_q + AW'(1);
          last_d    = (rd_cnt_q == len_q - AW'(1));
        end
        out_valid_d = rd_issue ? 1'b1 : (out_xfer ? 1'b0 : out_valid_q);
        if (out_xfer && last_q) begin
          if (pass_cnt_q < rpt_q) begin
            pass_cnt_d = pass_cnt_q + 4'd1;
            rd_cnt_d   = '0;
          end else begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy          = (state_q != IDLE);
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = bus.sram_dout;
  assign bus.out_last  = out_valid_q & last_q;
  assign bus.sram_cs   = sram_cs;
  assign bus.sram_we   = sram_we;
  assign bus.sram_wem  = sram_wem;
  assign bus.sram_addr = sram_addr;
  assign bus.sram_din  = sram_din;

endmodule

// File: tb/tb_input_pre_sram_ctrl.sv
// Randomized bench for input_pre_sram_ctrl: an SRAM model plus a frame-level
// reference (expected write list and replay queue) checked at the negedge.
module tb_input_pre_sram_ctrl;
  localparam int DP = 768;
  localparam int DW = 8;
  localparam int AW = 10;
  localparam int MW = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] cfg_len;
  logic [3:0]    cfg_rpt;
  logic          busy;
  logic          done;

  input_pre_sram_ctrl_if #(.DW(DW), .AW(AW), .MW(MW)) bus ();

  input_pre_sram_ctrl #(.DP(DP), .DW(DW), .AW(AW), .MW(MW)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .cfg_rpt(cfg_rpt),
    .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int wr_seen, out_seen, stall_cycles, sram_cnt = 0, done_cnt = 0;
  int last_in_cyc, first_out_cyc, last_out_cyc, done_cyc;
  logic [DW-1:0] exp_load [DP];
  logic [8:0]    exp_q [$];
  logic [8:0]    exp_word;
  bit            mon_en = 1'b0;
  bit            stall_prev = 1'b0;
  logic [DW-1:0] stall_data;
  int            ready_mode = 0;
  bit            stall_used = 1'b0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (bus.sram_cs) begin
      if (bus.sram_we) begin
        if (bus.sram_wem[0]) mem[bus.sram_addr] <= bus.sram_din;
      end else begin
        bus.sram_dout <= mem[bus.sram_addr];
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.sram_cs) sram_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (mon_en) begin
      if (bus.sram_cs && bus.sram_we) begin
        if (wr_seen < DP) begin
          checkOutput("wr_addr", 32'(bus.sram_addr), wr_seen);
          checkOutput("wr_data", 32'(bus.sram_din), 32'(exp_load[wr_seen]));
        end
        wr_seen++;
      end
      if (bus.in_valid && bus.in_ready) last_in_cyc = cyc;
      if (bus.out_valid && first_out_cyc < 0) first_out_cyc = cyc;
      if (stall_prev) begin
        checkOutput("stall_valid", 32'(bus.out_valid), 1);
        checkOutput("stall_data", 32'(bus.out_data), 32'(stall_data));
      end
      stall_prev = 1'b0;
      if (bus.out_valid && !bus.out_ready) begin
        stall_cycles++;
        stall_prev = 1'b1;
        stall_data = bus.out_data;
        checkOutput("stall_no_read", 32'(bus.sram_cs), 0);
      end
      if (bus.out_valid && bus.out_ready) begin
        out_seen++;
        last_out_cyc = cyc;
        if (exp_q.size() > 0) begin
          exp_word = exp_q.pop_front();
          checkOutput("out_word", 32'({bus.out_last, bus.out_data}), 32'(exp_word));
        end
      end
    end
  end

  // Consumer: always ready, random back-pressure, or one 3-cycle stall on 0x22.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        1: bus.out_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (!stall_used && bus.out_valid && bus.out_data == 8'h22) begin
            stall_used = 1'b1;
            bus.out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 bus.out_ready = 1'b1;
          end else begin
            bus.out_ready = 1'b1;
          end
        end
        default: bus.out_ready = 1'b1;
      endcase
    end
  end

  task automatic loadWord(input logic [DW-1:0] d, input int gap_max);
    int n;
    bit ok;
    bus.in_valid = 1'b0;
    repeat ($urandom_range(0, gap_max)) begin
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk); #1;
      n++;
    end
    bus.in_valid = 1'b0;
    if (!ok) checkOutput("load_handshake", 32'(bus.in_ready), 1);
  endtask

  task automatic applyStimulus(input int len_cfg, input int rpt, input int gap_max, input int rmode,
                               input bit seq_data, input bit restart_mid, input bit check_timing);
    int eff, done_base, budget;
    eff = (len_cfg > DP) ? DP : len_cfg;
    for (int i = 0; i < eff; i++) exp_load[i] = seq_data ? 8'((i + 1) * 8'h11) : 8'($urandom);
    exp_q.delete();
    for (int p = 0; p <= rpt; p++)
      for (int a = 0; a < eff; a++) exp_q.push_back({a == eff - 1, exp_load[a]});
    wr_seen = 0; out_seen = 0; stall_cycles = 0;
    first_out_cyc = -1; last_in_cyc = 0; last_out_cyc = 0;
    stall_used = 1'b0; stall_prev = 1'b0; ready_mode = rmode;
    done_base = done_cnt;
    mon_en = 1'b1;
    start = 1'b1; cfg_len = AW'(len_cfg); cfg_rpt = 4'(rpt);
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("busy_after_start", 32'(busy), 1);
    for (int i = 0; i < eff; i++) begin
      if (restart_mid && i == 2) begin
        start = 1'b1; cfg_len = AW'(2); cfg_rpt = 4'd3;
        @(posedge clk); #1;
        start = 1'b0;
      end
      loadWord(exp_load[i], gap_max);
    end
    budget = 0;
    while (budget < 20000) begin
      @(negedge clk);
      budget++;
      if (done) break;
    end
    checkOutput("done_seen", 32'(done), 1);
    @(negedge clk);
    checkOutput("done_pulse_end", 32'(done), 0);
    checkOutput("idle_busy", 32'(busy), 0);
    checkOutput("done_count", done_cnt - done_base, 1);
    checkOutput("wr_words", wr_seen, eff);
    checkOutput("out_words", out_seen, eff * (rpt + 1));
    if (check_timing) begin
      checkOutput("first_out_lat", first_out_cyc - last_in_cyc, 2);
      checkOutput("out_span", last_out_cyc - first_out_cyc, eff * (rpt + 1) - 1 + rpt);
      checkOutput("done_lat", done_cyc - last_out_cyc, 1);
    end
    if (rmode == 2) checkOutput("stall_cycles", stall_cycles, 3);
    mon_en = 1'b0;
    ready_mode = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    int base_sram, base_done;
    #800000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base_sram, base_done;
    rst = 1'b1; start = 1'b0; cfg_len = '0; cfg_rpt = '0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 0);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 0);
    checkOutput("rst_sram_cs", 32'(bus.sram_cs), 0);
    checkOutput("rst_sram_we", 32'(bus.sram_we), 0);
    @(posedge clk); #1;

    applyStimulus(4, 0, 0, 0, 1'b1, 1'b0, 1'b1);
    applyStimulus(4, 2, 0, 0, 1'b1, 1'b0, 1'b1);
    applyStimulus(4, 0, 0, 2, 1'b1, 1'b0, 1'b0);
    applyStimulus(1000, 0, 2, 1, 1'b0, 1'b0, 1'b0);

    base_sram = sram_cnt; base_done = done_cnt;
    start = 1'b1; cfg_len = '0; cfg_rpt = 4'd2;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("zero_len_busy", 32'(busy), 0);
    end
    checkOutput("zero_len_sram", sram_cnt - base_sram, 0);
    checkOutput("zero_len_done", done_cnt - base_done, 0);
    @(posedge clk); #1;

    applyStimulus(6, 1, 1, 1, 1'b0, 1'b1, 1'b0);

    // Abort a frame after two of four load words.
    for (int i = 0; i < 4; i++) exp_load[i] = 8'($urandom);
    wr_seen = 0; first_out_cyc = -1; stall_prev = 1'b0; mon_en = 1'b1;
    base_done = done_cnt;
    start = 1'b1; cfg_len = AW'(4); cfg_rpt = 4'd0;
    @(posedge clk); #1;
    start = 1'b0;
    loadWord(exp_load[0], 0);
    loadWord(exp_load[1], 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("abort_busy", 32'(busy), 0);
    checkOutput("abort_in_ready", 32'(bus.in_ready), 0);
    checkOutput("abort_out_valid", 32'(bus.out_valid), 0);
    repeat (4) @(negedge clk);
    checkOutput("abort_no_done", done_cnt - base_done, 0);
    checkOutput("abort_wr_words", wr_seen, 2);
    mon_en = 1'b0;
    @(posedge clk); #1;

    rst = 1'b1; start = 1'b1; cfg_len = AW'(5);
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checkOutput("rst_over_start", 32'(busy), 0);
    @(posedge clk); #1;

    applyStimulus(4, 0, 0, 0, 1'b1, 1'b0, 1'b1);

    for (int k = 0; k < 6; k++)
      applyStimulus($urandom_range(1, 40), $urandom_range(0, 3), $urandom_range(0, 2), 1, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
